// File: rtl/hmi_pkg.sv
// -----------------------------------------------------------------------------
// hmi_pkg
// Shared definitions for the HMI LED driver: LED vector width, Avalon register
// word addresses, ctrl register bit positions and register reset values.
// No ports (package).
// -----------------------------------------------------------------------------
package hmi_pkg;

   localparam int LED_WIDTH = 10;

   // Avalon word addresses of the s1 slave
   localparam logic [1:0] ADDR_BRIGHT       = 2'd0;
   localparam logic [1:0] ADDR_BLINK_MASK   = 2'd1;
   localparam logic [1:0] ADDR_BLINK_PERIOD = 2'd2;
   localparam logic [1:0] ADDR_CTRL         = 2'd3;

   // ctrl register bit indices
   localparam int CTRL_ENABLE = 0;
   localparam int CTRL_INVERT = 1;
   localparam int CTRL_PHASE  = 2;   // read-only blink phase

   // Register reset values (blink period reset is a module parameter)
   localparam logic [7:0]           BRIGHT_RST = 8'hFF;
   localparam logic [LED_WIDTH-1:0] MASK_RST   = '0;
   localparam logic                 ENABLE_RST = 1'b1;
   localparam logic                 INVERT_RST = 1'b0;
   localparam logic                 PHASE_RST  = 1'b1;

   // PWM compare: full scale is forced on so 8'hFF never shows the single
   // dark step that a plain "cnt < level" compare would give at cnt == 255.
   function automatic logic pwm_compare(input logic [7:0] cnt, input logic [7:0] level);
      return (level == 8'hFF) || (cnt < level);
   endfunction

endpackage

// File: rtl/hmi_tick_gen.sv
// -----------------------------------------------------------------------------
// hmi_tick_gen
// Modulo-DIV prescaler. Counts 0..DIV-1 and wraps; tick is high for exactly
// the one clock in which the counter sits at DIV-1 (the wrap cycle).
// Ports:
//   clk      in  system clock
//   reset_n  in  asynchronous active-low reset (counter returns to 0)
//   tick     out 1-cycle pulse on wrap
// -----------------------------------------------------------------------------
module hmi_tick_gen #(
   parameter int DIV = 4
) (
   input  logic clk,
   input  logic reset_n,
   output logic tick
);

   localparam int              CW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0]   LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_reg;
   logic [CW-1:0] cnt_next;

   always_comb begin
      cnt_next = cnt_reg + CW'(1);
      if (cnt_reg == LAST) begin
         cnt_next = '0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_next;
      end
   end

   assign tick = (cnt_reg == LAST);

endmodule

// File: rtl/hmi_led_driver.sv
// -----------------------------------------------------------------------------
// hmi_led_driver
// Post-processes the LED PIO output before it reaches the board pins:
// global PWM brightness, per-LED blink, global enable and polarity invert.
// Configured through a 4-word zero-wait-state Avalon-MM slave.
// Ports:
//   clk         in  system clock
//   reset_n     in  asynchronous active-low reset
//   address     in  Avalon word address (0 bright, 1 mask, 2 period, 3 ctrl)
//   chipselect  in  Avalon select
//   write_n     in  Avalon write strobe, active-low
//   writedata   in  Avalon write data
//   readdata    out Avalon read data, combinational, zero-extended
//   led_in      in  LED request from PIO out_port
//   led_pin     out registered drive to board LEDs
// -----------------------------------------------------------------------------
module hmi_led_driver
   import hmi_pkg::*;
#(
   parameter int PWM_DIV   = 196,
   parameter int TICK_DIV  = 50000,
   parameter int BLINK_RST = 500
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [1:0]           address,
   input  logic                 chipselect,
   input  logic                 write_n,
   input  logic [31:0]          writedata,
   output logic [31:0]          readdata,
   input  logic [LED_WIDTH-1:0] led_in,
   output logic [LED_WIDTH-1:0] led_pin
);

   localparam logic [15:0] PERIOD_RST = 16'(BLINK_RST);

   // ---------------------------------------------------------------- registers
   logic [7:0]           bright_reg;
   logic [LED_WIDTH-1:0] mask_reg;
   logic [15:0]          period_reg;
   logic                 enable_reg;
   logic                 invert_reg;
   logic                 phase_reg;
   logic                 phase_next;
   logic [15:0]          blink_cnt_reg;
   logic [15:0]          blink_cnt_next;
   logic [7:0]           pwm_cnt_reg;
   logic [LED_WIDTH-1:0] led_pin_reg;
   logic [LED_WIDTH-1:0] eff;

   logic pwm_tick;
   logic blink_tick;
   logic pwm_on;
   logic wr_en;
   logic wr_period;

   // Upper write-data bits have no destination
   logic unused_bits;
   assign unused_bits = ^writedata[31:16];

   assign wr_en     = chipselect & ~write_n;
   assign wr_period = wr_en && (address == ADDR_BLINK_PERIOD);

   // ---------------------------------------------------------------- prescalers
   hmi_tick_gen #(.DIV(PWM_DIV)) u_pwm_tick (
      .clk     (clk),
      .reset_n (reset_n),
      .tick    (pwm_tick)
   );

   hmi_tick_gen #(.DIV(TICK_DIV)) u_blink_tick (
      .clk     (clk),
      .reset_n (reset_n),
      .tick    (blink_tick)
   );

   // ---------------------------------------------------------------- slave writes
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bright_reg <= BRIGHT_RST;
         mask_reg   <= MASK_RST;
         period_reg <= PERIOD_RST;
         enable_reg <= ENABLE_RST;
         invert_reg <= INVERT_RST;
      end else if (wr_en) begin
         case (address)
            ADDR_BRIGHT:       bright_reg <= writedata[7:0];
            ADDR_BLINK_MASK:   mask_reg   <= writedata[LED_WIDTH-1:0];
            ADDR_BLINK_PERIOD: period_reg <= writedata[15:0];
            ADDR_CTRL: begin
               enable_reg <= writedata[CTRL_ENABLE];
               invert_reg <= writedata[CTRL_INVERT];
            end
            default: ;
         endcase
      end
   end

   // ---------------------------------------------------------------- slave reads
   always_comb begin
      readdata = '0;
      case (address)
         ADDR_BRIGHT:       readdata[7:0]           = bright_reg;
         ADDR_BLINK_MASK:   readdata[LED_WIDTH-1:0] = mask_reg;
         ADDR_BLINK_PERIOD: readdata[15:0]          = period_reg;
         ADDR_CTRL: begin
            readdata[CTRL_ENABLE] = enable_reg;
            readdata[CTRL_INVERT] = invert_reg;
            readdata[CTRL_PHASE]  = phase_reg;
         end
         default: ;
      endcase
   end

   // ---------------------------------------------------------------- PWM
   // The PWM step counter free-runs; brightness changes are picked up at the
   // next compare without restarting the period.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pwm_cnt_reg <= '0;
      end else if (pwm_tick) begin
         pwm_cnt_reg <= pwm_cnt_reg + 8'd1;
      end
   end

   assign pwm_on = pwm_compare(pwm_cnt_reg, bright_reg);

   // ---------------------------------------------------------------- blink
   // Priority: a period write restarts the blink cycle (even on a tick edge),
   // then a zero period parks the phase on, then normal tick counting.
   always_comb begin
      blink_cnt_next = blink_cnt_reg;
      phase_next     = phase_reg;
      if (wr_period) begin
         blink_cnt_next = '0;
         phase_next     = 1'b1;
      end else if (period_reg == 16'd0) begin
         blink_cnt_next = '0;
         phase_next     = 1'b1;
      end else if (blink_tick) begin
         if (blink_cnt_reg == period_reg - 16'd1) begin
            blink_cnt_next = '0;
            phase_next     = ~phase_reg;
         end else begin
            blink_cnt_next = blink_cnt_reg + 16'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         blink_cnt_reg <= '0;
         phase_reg     <= PHASE_RST;
      end else begin
         blink_cnt_reg <= blink_cnt_next;
         phase_reg     <= phase_next;
      end
   end

   // ---------------------------------------------------------------- output
   genvar gi;
   generate
      for (gi = 0; gi < LED_WIDTH; gi++) begin : g_led
         assign eff[gi] = enable_reg & led_in[gi] & pwm_on & (~mask_reg[gi] | phase_reg);
      end
   endgenerate

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         led_pin_reg <= '0;
      end else begin
         led_pin_reg <= eff ^ {LED_WIDTH{invert_reg}};
      end
   end

   assign led_pin = led_pin_reg;

endmodule

// File: tb/tb_hmi_led_driver.sv
// -----------------------------------------------------------------------------
// tb_hmi_led_driver
// Self-checking bench for hmi_led_driver with short prescalers
// (PWM_DIV = 3, TICK_DIV = 4) so full PWM periods and blink cycles are short.
// Expected values are queued when stimulus is applied and popped when the
// corresponding DUT output is sampled (inputs driven and outputs sampled on
// the falling clock edge).
// -----------------------------------------------------------------------------
module tb_hmi_led_driver;

   localparam int PWM_DIV  = 3;
   localparam int TICK_DIV = 4;
   localparam int PWM_PER  = 256 * PWM_DIV;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [1:0]  address = 2'd0;
   logic        chipselect = 1'b0;
   logic        write_n = 1'b1;
   logic [31:0] writedata = '0;
   logic [31:0] readdata;
   logic [9:0]  led_in = 10'h3FF;
   logic [9:0]  led_pin;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   hmi_led_driver #(
      .PWM_DIV   (PWM_DIV),
      .TICK_DIV  (TICK_DIV),
      .BLINK_RST (500)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .led_in     (led_in),
      .led_pin    (led_pin)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %-16s got 0x%0h expected 0x%0h", tag, obs, exp);
      end else begin
         $display("ok   %-16s 0x%0h", tag, obs);
      end
   endtask

   task automatic expect_push(input string tag, input logic [31:0] v);
      exp_t e;
      e.tag = tag;
      e.val = v;
      sb.push_back(e);
   endtask

   task automatic expect_pop(input logic [31:0] obs);
      exp_t e;
      if (sb.size() == 0) begin
         check("sb_underflow", 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         check(e.tag, obs, e.val);
      end
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
      @(negedge clk);
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   task automatic bus_read(input string tag, input logic [1:0] a, input logic [31:0] exp);
      @(negedge clk);
      address = a;
      expect_push(tag, exp);
      #1;
      expect_pop(readdata);
   endtask

   // Random led_in each cycle; led_pin must follow one cycle later
   // (brightness full scale, no blink mask).
   task automatic stream(input string tag, input int n, input logic en, input logic inv);
      logic [9:0] v;
      for (int i = 0; i <= n; i++) begin
         @(negedge clk);
         if (i > 0) expect_pop({22'd0, led_pin});
         if (i < n) begin
            v = 10'($urandom);
            led_in = v;
            expect_push(tag, {22'd0, (en ? v : 10'h000) ^ {10{inv}}});
         end
      end
   endtask

   // Count clocks with led_pin[0] high over one full PWM period
   task automatic pwm_measure(input logic [7:0] level);
      int hi;
      bus_write(2'd0, {24'd0, level});
      repeat (2) @(negedge clk);
      expect_push($sformatf("pwm_b%0d", level), (level == 8'hFF) ? PWM_PER : level * PWM_DIV);
      hi = 0;
      for (int c = 0; c < PWM_PER; c++) begin
         @(negedge clk);
         if (led_pin[0] === 1'b1) hi++;
      end
      expect_pop(hi);
   endtask

   initial begin
      int   ivl_done, last_t, bad0, badph, zero_ph, found;
      logic prev_ph, prev_led;
      logic [7:0] levels [5];

      // ---------------- reset and first edge
      repeat (3) @(negedge clk);
      expect_push("rst_led", 32'h000);
      expect_pop({22'd0, led_pin});
      reset_n = 1'b1;
      expect_push("first_edge", 32'h3FF);
      @(negedge clk);
      expect_pop({22'd0, led_pin});
      bus_read("rd_bright", 2'd0, 32'hFF);
      bus_read("rd_mask", 2'd1, 32'h0);
      bus_read("rd_period", 2'd2, 32'd500);
      bus_read("rd_ctrl", 2'd3, 32'h5);

      // ---------------- pass-through, enable and invert
      stream("pass", 6, 1'b1, 1'b0);
      bus_write(2'd3, 32'h2);
      stream("ctrl2_dis_inv", 6, 1'b0, 1'b1);
      bus_write(2'd3, 32'h3);
      @(negedge clk);
      led_in = 10'h00F;
      expect_push("ctrl3_00f", 32'h3F0);
      @(negedge clk);
      expect_pop({22'd0, led_pin});
      stream("ctrl3_inv", 4, 1'b1, 1'b1);
      bus_write(2'd3, 32'hFF);          // phase bit and upper bits ignored
      bus_read("rd_ctrl_wr", 2'd3, 32'h7);
      bus_write(2'd3, 32'h1);

      // ---------------- PWM duty
      led_in = 10'h001;
      levels = '{8'd64, 8'd0, 8'd255, 8'd1, 8'd254};
      foreach (levels[k]) pwm_measure(levels[k]);
      bus_write(2'd0, 32'hFF);

      // ---------------- blink: period 3 ticks of 4 clocks -> 12-clock half period
      led_in = 10'h003;
      bus_write(2'd1, 32'h002);
      bus_write(2'd2, 32'd3);
      bus_read("rd_period3", 2'd2, 32'd3);
      address = 2'd3;
      #1;
      for (int k = 0; k < 3; k++) expect_push("blink_ivl", 32'd12);
      prev_ph = readdata[2]; prev_led = led_pin[1];
      ivl_done = 0; last_t = -1; bad0 = 0; badph = 0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (led_pin[1] !== prev_ph) badph++;
         if (led_pin[0] !== 1'b1) bad0++;
         if (led_pin[1] !== prev_led) begin
            if (last_t >= 0 && ivl_done < 3) begin
               expect_pop(c - last_t);
               ivl_done++;
            end
            last_t = c;
         end
         prev_led = led_pin[1];
         prev_ph = readdata[2];
      end
      check("blink_ivl_count", ivl_done, 3);
      while (ivl_done < 3) begin void'(sb.pop_front()); ivl_done++; end
      check("blink_led0_low", bad0, 0);
      check("phase_vs_led1", badph, 0);

      // ---------------- period write coincident with the wrapping tick
      found = 0;
      prev_ph = readdata[2];
      for (int c = 0; c < 40 && found == 0; c++) begin
         @(negedge clk);
         if (prev_ph === 1'b0 && readdata[2] === 1'b1) found = 1;
         prev_ph = readdata[2];
      end
      check("sync_found", found, 1);
      repeat (11) @(negedge clk);
      chipselect = 1'b1; write_n = 1'b0; address = 2'd2; writedata = 32'd3;
      @(negedge clk);
      chipselect = 1'b0; write_n = 1'b1; address = 2'd3;
      #1;
      expect_push("wr_tick_phase", 32'd1);
      expect_pop({31'd0, readdata[2]});
      zero_ph = 0;
      for (int c = 0; c < 11; c++) begin
         @(negedge clk);
         if (readdata[2] !== 1'b1) zero_ph++;
      end
      check("wr_tick_hold", zero_ph, 0);
      @(negedge clk);
      check("wr_tick_retog", {31'd0, readdata[2]}, 32'd0);

      // ---------------- zero period parks phase at 1
      bus_write(2'd2, 32'd0);
      address = 2'd3;
      zero_ph = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (readdata[2] !== 1'b1) zero_ph++;
      end
      check("period0_phase", zero_ph, 0);

      // ---------------- asynchronous reset mid-blink with phase 0
      led_in = 10'h3FF;
      bus_write(2'd2, 32'd3);
      address = 2'd3;
      found = 0;
      for (int c = 0; c < 40 && found == 0; c++) begin
         @(negedge clk);
         if (readdata[2] === 1'b0) found = 1;
      end
      check("phase0_found", found, 1);
      @(negedge clk);
      check("blink_off_led", {22'd0, led_pin}, 32'h3FD);
      #2;
      reset_n = 1'b0;
      #1;
      check("async_clr", {22'd0, led_pin}, 32'h000);
      @(negedge clk);
      reset_n = 1'b1;
      bus_read("rd_bright_rst", 2'd0, 32'hFF);
      bus_read("rd_mask_rst", 2'd1, 32'h0);
      bus_read("rd_period_rst", 2'd2, 32'd500);
      bus_read("rd_ctrl_rst", 2'd3, 32'h5);

      check("sb_drained", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
